// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one core access at a time, issues a single
// memory cycle, formats load data and holds the response until the core takes it.
module lsu_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic                      req_we_i,
  input  logic [1:0]                req_size_i,
  input  logic                      req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0]     req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  output logic                      resp_valid_o,
  input  logic                      resp_ready_i,
  output logic [DATA_WIDTH-1:0]     resp_rdata_o,
  output logic                      resp_err_o,
  output logic                      mem_en_o,
  output logic [DATA_WIDTH/8-1:0]   mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, LATCH, RESP} state_t;

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // valid/payload from the producer stay stable until that edge.
  state_t     state;
  logic       op_we;
  logic [1:0] op_size;
  logic       op_unsigned;
  logic [1:0] op_off;

  logic            accept;
  logic            req_err;
  logic [NB-1:0]   strobe;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;
  logic [DATA_WIDTH-1:0] load_data;

  assign req_ready_o = (state == IDLE) && rst_n_i;
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    req_err = 1'b0;
    case (req_size_i)
      2'b01:   req_err = req_addr_i[0];
      2'b10:   req_err = (req_addr_i[1:0] != 2'b00);
      2'b11:   req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end

  always_comb begin
    strobe = '0;
    case (req_size_i)
      2'b00:   strobe[0]   = 1'b1;
      2'b01:   strobe[1:0] = 2'b11;
      default: strobe      = '1;
    endcase
  end

  // Lanes are picked from the word at the aligned address using the kept low bits.
  always_comb begin
    byte_lane = mem_rdata_i[{op_off, 3'b000} +: 8];
    half_lane = mem_rdata_i[{op_off[1], 4'b0000} +: 16];
    load_data = mem_rdata_i;
    case (op_size)
      2'b00: load_data = op_unsigned ? {{(DATA_WIDTH-8){1'b0}}, byte_lane}
                                     : {{(DATA_WIDTH-8){byte_lane[7]}}, byte_lane};
      2'b01: load_data = op_unsigned ? {{(DATA_WIDTH-16){1'b0}}, half_lane}
                                     : {{(DATA_WIDTH-16){half_lane[15]}}, half_lane};
      default: load_data = mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state        <= IDLE;
      op_we        <= 1'b0;
      op_size      <= 2'b00;
      op_unsigned  <= 1'b0;
      op_off       <= 2'b00;
      resp_valid_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_rdata_o <= '0;
      mem_en_o     <= 1'b0;
      mem_we_o     <= '0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_we       <= req_we_i;
            op_size     <= req_size_i;
            op_unsigned <= req_unsigned_i;
            op_off      <= req_addr_i[1:0];
            if (req_err) begin
              state        <= RESP;
              resp_valid_o <= 1'b1;
              resp_err_o   <= 1'b1;
              resp_rdata_o <= '0;
            end else begin
              state       <= ISSUE;
              mem_en_o    <= 1'b1;
              mem_we_o    <= req_we_i ? strobe : '0;
              mem_addr_o  <= req_addr_i;
              mem_wdata_o <= req_wdata_i;
            end
          end
        end
        ISSUE: begin
          mem_en_o <= 1'b0;
          mem_we_o <= '0;
          if (op_we) begin
            state        <= RESP;
            resp_valid_o <= 1'b1;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
          end else begin
            state <= LATCH;
          end
        end
        LATCH: begin
          state        <= RESP;
          resp_valid_o <= 1'b1;
          resp_err_o   <= 1'b0;
          resp_rdata_o <= load_data;
        end
        RESP: begin
          if (resp_ready_i) begin
            state        <= IDLE;
            resp_valid_o <= 1'b0;
            resp_err_o   <= 1'b0;
            resp_rdata_o <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed spot checks, reset-abort case and random accesses
// compared cycle by cycle against a byte-lane reference model.
module tb_lsu_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic        req_unsigned_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        resp_valid_o;
  logic        resp_ready_i = 1'b0;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        mem_en_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;

  int n_cmp = 0;
  int n_err = 0;

  lsu_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
    .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .mem_en_o(mem_en_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access rules written as plain arithmetic on bytes.
  function automatic bit model_err(input logic [1:0] size, input logic [31:0] addr);
    int nbytes;
    if (size == 2'b11) return 1'b1;
    nbytes = 1 << size;
    return (addr % nbytes) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    longint unsigned word, lane, span;
    int nbytes, off;
    nbytes = 1 << size;
    off    = int'(addr % 4);
    word   = rdata;
    span   = 64'd1 << (8 * nbytes);
    lane   = (word >> (8 * off)) % span;
    if (!uns && lane >= span / 2) lane = lane - span;
    return lane[31:0];
  endfunction

  function automatic logic [31:0] model_strobe(input logic [1:0] size);
    return (32'd1 << (1 << size)) - 32'd1;
  endfunction

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_junk();
    req_valid_i    = 1'($urandom_range(0, 1));
    req_we_i       = 1'($urandom_range(0, 1));
    req_size_i     = 2'($urandom_range(0, 3));
    req_unsigned_i = 1'($urandom_range(0, 1));
    req_addr_i     = $urandom;
    req_wdata_i    = $urandom;
    mem_rdata_i    = $urandom;
  endtask

  task automatic do_reset();
    rst_n_i = 1'b0;
    req_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk_i);
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_resp_err", 32'(resp_err_o), 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_mem_en", 32'(mem_en_o), 32'd0);
    chk("rst_mem_we", 32'(mem_we_o), 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wdata", mem_wdata_o, 32'd0);
    rst_n_i = 1'b1;
    next_cycle();
  endtask

  // One full access: accept, busy cycles with junk on the request side, held response.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int hold);
    bit          err;
    int          busy;
    logic [31:0] exp_rdata;
    logic [31:0] last_addr;
    err       = model_err(size, addr);
    busy      = err ? 0 : (we ? 1 : 2);
    exp_rdata = (err || we) ? 32'd0 : model_load(size, uns, addr, rdata);
    last_addr = mem_addr_o;
    @(negedge clk_i);
    chk("idle_ready", 32'(req_ready_o), 32'd1);
    req_valid_i = 1'b1; req_we_i = we; req_size_i = size; req_unsigned_i = uns;
    req_addr_i = addr; req_wdata_i = wdata;
    next_cycle();
    for (int i = 0; i < busy; i++) begin
      drive_junk();
      resp_ready_i = 1'($urandom_range(0, 1));
      if (i == 1) mem_rdata_i = rdata;
      @(negedge clk_i);
      chk("busy_ready", 32'(req_ready_o), 32'd0);
      chk("busy_resp_valid", 32'(resp_valid_o), 32'd0);
      chk("busy_mem_en", 32'(mem_en_o), (i == 0) ? 32'd1 : 32'd0);
      chk("busy_mem_we", 32'(mem_we_o), (i == 0 && we) ? model_strobe(size) : 32'd0);
      chk("busy_mem_addr", mem_addr_o, addr);
      if (we) chk("busy_mem_wdata", mem_wdata_o, wdata);
      next_cycle();
    end
    if (err) chk("err_addr_held", mem_addr_o, last_addr);
    for (int h = 0; h <= hold; h++) begin
      drive_junk();
      resp_ready_i = 1'b0;
      @(negedge clk_i);
      chk("resp_valid", 32'(resp_valid_o), 32'd1);
      chk("resp_err", 32'(resp_err_o), 32'(err));
      chk("resp_rdata", resp_rdata_o, exp_rdata);
      chk("resp_ready_low", 32'(req_ready_o), 32'd0);
      chk("resp_mem_en", 32'(mem_en_o), 32'd0);
      chk("resp_mem_we", 32'(mem_we_o), 32'd0);
      if (h < hold) next_cycle();
    end
    resp_ready_i = 1'b1;
    next_cycle();
    req_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    @(negedge clk_i);
    chk("post_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("post_ready", 32'(req_ready_o), 32'd1);
    chk("post_mem_en", 32'(mem_en_o), 32'd0);
  endtask

  initial begin
    do_reset();

    run_txn(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    run_txn(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'hDEADBEEF, 0);
    run_txn(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, 32'hDEADBEEF, 1);
    run_txn(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    run_txn(1'b1, 2'b01, 1'b0, 32'h102, 32'h1234, 32'h0, 0);
    run_txn(1'b1, 2'b00, 1'b0, 32'h101, 32'h000000A5, 32'h0, 0);
    run_txn(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 32'hDEADBEEF, 0);
    run_txn(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 0);
    run_txn(1'b1, 2'b10, 1'b0, 32'h204, 32'hCAFEF00D, 32'h0, 3);
    run_txn(1'b0, 2'b00, 1'b1, 32'h0FF, 32'h0, 32'h80FF7F01, 3);

    // Reset landing in ISSUE of a load aborts it with no response.
    @(negedge clk_i);
    req_valid_i = 1'b1; req_we_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
    req_addr_i = 32'h300; req_wdata_i = 32'h0;
    next_cycle();
    req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("abort_issue_en", 32'(mem_en_o), 32'd1);
    rst_n_i = 1'b0;
    next_cycle();
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("abort_mem_en", 32'(mem_en_o), 32'd0);
    chk("abort_mem_addr", mem_addr_o, 32'd0);
    chk("abort_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("abort_ready", 32'(req_ready_o), 32'd1);
    for (int c = 0; c < 5; c++) begin
      mem_rdata_i = $urandom;
      next_cycle();
      @(negedge clk_i);
      chk("abort_no_resp", 32'(resp_valid_o), 32'd0);
      chk("abort_idle", 32'(req_ready_o), 32'd1);
    end

    for (int t = 0; t < 200; t++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      sz = 2'($urandom_range(0, 3));
      ad = {$urandom_range(0, 32'h3FFF), 2'b00} | 32'($urandom_range(0, 3));
      run_txn(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad,
              $urandom, $urandom, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
